// File: rtl/gp_regfile_sb.sv
// Parametrised register file: two forwarding read ports, a per-register busy scoreboard
// and a sequenced clear engine that re-initialises storage without reset.
module gp_regfile_sb #(
  parameter int unsigned   DW        = 32,
  parameter int unsigned   DEPTH     = 16,
  parameter int unsigned   AW        = 4,
  parameter int unsigned   LANES     = 2,
  parameter logic [DW-1:0] RESET_VAL = '0,
  parameter bit            ZERO_R0   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen_i,
  input  logic [AW-1:0]    w_idx_i,
  input  logic [DW-1:0]    wdata_i,
  input  logic [LANES-1:0] w_lane_i,
  input  logic             w_release_i,
  input  logic             claim_i,
  input  logic [AW-1:0]    claim_idx_i,
  input  logic [AW-1:0]    ra_idx_i,
  input  logic             ren_a_i,
  input  logic [AW-1:0]    rb_idx_i,
  input  logic             ren_b_i,
  output logic [DW-1:0]    rdata_a_o,
  output logic [DW-1:0]    rdata_b_o,
  output logic             busy_a_o,
  output logic             busy_b_o,
  input  logic             clr_req_i,
  output logic             clr_busy_o,
  output logic             clr_done_o,
  output logic             wr_ready_o
);

  localparam int unsigned LW = DW / LANES;

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DW-1:0]     wmask;
  logic              wr_ready;
  logic [DEPTH-1:0]  wr_hit, clm_hit, rel_hit;

  assign wr_ready   = (state_q == StIdle);
  assign wr_ready_o = wr_ready;
  assign clr_busy_o = (state_q == StSweep);
  assign clr_done_o = (state_q == StDone);

  always_comb begin
    wmask = '0;
    for (int k = 0; k < LANES; k++) begin
      wmask[k*LW +: LW] = {LW{w_lane_i[k]}};
    end
  end

  // Per-register accept decode; out-of-range indices never match any entry.
  always_comb begin
    wr_hit  = '0;
    clm_hit = '0;
    rel_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!(ZERO_R0 && i == 0)) begin
        wr_hit[i]  = wen_i && wr_ready && (w_idx_i == AW'(i));
        clm_hit[i] = claim_i && wr_ready && (claim_idx_i == AW'(i));
        rel_hit[i] = wr_hit[i] && w_release_i;
      end
    end
  end

  always_comb begin
    rdata_a_o = RESET_VAL;
    busy_a_o  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst && ren_a_i && (ra_idx_i == AW'(i)) && !(ZERO_R0 && i == 0)) begin
        rdata_a_o = wr_hit[i] ? ((regs_q[i] & ~wmask) | (wdata_i & wmask)) : regs_q[i];
        busy_a_o  = busy_q[i];
      end
    end
  end

  always_comb begin
    rdata_b_o = RESET_VAL;
    busy_b_o  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst && ren_b_i && (rb_idx_i == AW'(i)) && !(ZERO_R0 && i == 0)) begin
        rdata_b_o = wr_hit[i] ? ((regs_q[i] & ~wmask) | (wdata_i & wmask)) : regs_q[i];
        busy_b_o  = busy_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (clr_req_i) begin
          state_d = StSweep;
          cnt_d   = '0;
        end
      end
      StSweep: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = StDone;
          cnt_d   = '0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (state_q == StSweep && cnt_q == AW'(i)) begin
          regs_q[i] <= RESET_VAL;
          busy_q[i] <= 1'b0;
        end else begin
          if (wr_hit[i]) begin
            regs_q[i] <= (regs_q[i] & ~wmask) | (wdata_i & wmask);
          end
          // A claim in the same cycle as a release marks the new producer.
          if (clm_hit[i]) begin
            busy_q[i] <= 1'b1;
          end else if (rel_hit[i]) begin
            busy_q[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gp_regfile_sb.sv
// Bench for gp_regfile_sb: a plain-array model checked every cycle against two instances
// (ZERO_R0=0 with AW=4, ZERO_R0=1 with AW=5), directed scenarios and random traffic.
module tb_gp_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen, w_release, claim, ren_a, ren_b, clr_req;
  logic [4:0]  w_idx, claim_idx, ra_idx, rb_idx;
  logic [31:0] wdata;
  logic [1:0]  w_lane;

  logic [31:0] rda [2];
  logic [31:0] rdb [2];
  logic        bsa [2];
  logic        bsb [2];
  logic        cbusy [2];
  logic        cdone [2];
  logic        wrdy [2];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mreg  [2][16];
  logic        mbusy [2][16];
  int          phase;  // 0 idle, 1..16 sweep position+1, 17 done

  always #5 clk = ~clk;

  gp_regfile_sb #(.DW(32), .DEPTH(16), .AW(4), .LANES(2), .RESET_VAL(32'h0), .ZERO_R0(1'b0)) u_n (
    .clk(clk), .rst(rst), .wen_i(wen), .w_idx_i(w_idx[3:0]), .wdata_i(wdata), .w_lane_i(w_lane),
    .w_release_i(w_release), .claim_i(claim), .claim_idx_i(claim_idx[3:0]),
    .ra_idx_i(ra_idx[3:0]), .ren_a_i(ren_a), .rb_idx_i(rb_idx[3:0]), .ren_b_i(ren_b),
    .rdata_a_o(rda[0]), .rdata_b_o(rdb[0]), .busy_a_o(bsa[0]), .busy_b_o(bsb[0]),
    .clr_req_i(clr_req), .clr_busy_o(cbusy[0]), .clr_done_o(cdone[0]), .wr_ready_o(wrdy[0])
  );

  gp_regfile_sb #(.DW(32), .DEPTH(16), .AW(5), .LANES(2), .RESET_VAL(32'h0), .ZERO_R0(1'b1)) u_z (
    .clk(clk), .rst(rst), .wen_i(wen), .w_idx_i(w_idx), .wdata_i(wdata), .w_lane_i(w_lane),
    .w_release_i(w_release), .claim_i(claim), .claim_idx_i(claim_idx),
    .ra_idx_i(ra_idx), .ren_a_i(ren_a), .rb_idx_i(rb_idx), .ren_b_i(ren_b),
    .rdata_a_o(rda[1]), .rdata_b_o(rdb[1]), .busy_a_o(bsa[1]), .busy_b_o(bsb[1]),
    .clr_req_i(clr_req), .clr_busy_o(cbusy[1]), .clr_done_o(cdone[1]), .wr_ready_o(wrdy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int eidx(input int inst, input logic [4:0] x);
    return (inst == 0) ? int'(x[3:0]) : int'(x);
  endfunction

  function automatic bit usable(input int inst, input int idx);
    return idx < 16 && !(inst == 1 && idx == 0);
  endfunction

  function automatic logic [31:0] lane_mask();
    return {{16{w_lane[1]}}, {16{w_lane[0]}}};
  endfunction

  function automatic logic [31:0] exp_data(input int inst, input logic [4:0] ridx, input logic en);
    int idx = eidx(inst, ridx);
    logic [31:0] v;
    if (rst || !en || !usable(inst, idx)) return 32'h0;
    v = mreg[inst][idx];
    if (wen && phase == 0 && eidx(inst, w_idx) == idx) v = (v & ~lane_mask()) | (wdata & lane_mask());
    return v;
  endfunction

  function automatic logic exp_busy(input int inst, input logic [4:0] ridx, input logic en);
    int idx = eidx(inst, ridx);
    if (rst || !en || !usable(inst, idx)) return 1'b0;
    return mbusy[inst][idx];
  endfunction

  task automatic model_reset();
    phase = 0;
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < 16; i++) begin
        mreg[n][i]  = 32'h0;
        mbusy[n][i] = 1'b0;
      end
  endtask

  task automatic model_edge();
    int wi, ci;
    if (phase == 0) begin
      for (int n = 0; n < 2; n++) begin
        wi = eidx(n, w_idx);
        ci = eidx(n, claim_idx);
        if (wen && usable(n, wi)) begin
          mreg[n][wi] = (mreg[n][wi] & ~lane_mask()) | (wdata & lane_mask());
          if (w_release) mbusy[n][wi] = 1'b0;
        end
        if (claim && usable(n, ci)) mbusy[n][ci] = 1'b1;
      end
      if (clr_req) phase = 1;
    end else if (phase <= 16) begin
      for (int n = 0; n < 2; n++) begin
        mreg[n][phase-1]  = 32'h0;
        mbusy[n][phase-1] = 1'b0;
      end
      phase++;
    end else begin
      phase = 0;
    end
  endtask

  task automatic compare();
    for (int n = 0; n < 2; n++) begin
      check($sformatf("rdata_a[%0d]", n), rda[n], exp_data(n, ra_idx, ren_a));
      check($sformatf("rdata_b[%0d]", n), rdb[n], exp_data(n, rb_idx, ren_b));
      check($sformatf("busy_a[%0d]", n), 32'(bsa[n]), 32'(exp_busy(n, ra_idx, ren_a)));
      check($sformatf("busy_b[%0d]", n), 32'(bsb[n]), 32'(exp_busy(n, rb_idx, ren_b)));
      check($sformatf("clr_busy[%0d]", n), 32'(cbusy[n]),
            32'(!rst && phase >= 1 && phase <= 16));
      check($sformatf("clr_done[%0d]", n), 32'(cdone[n]), 32'(!rst && phase == 17));
      check($sformatf("wr_ready[%0d]", n), 32'(wrdy[n]), 32'(rst || phase == 0));
    end
  endtask

  task automatic settle();
    if (rst) model_reset();
    #1;
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic idle_inputs();
    wen = 0; w_release = 0; claim = 0; ren_a = 0; ren_b = 0; clr_req = 0;
    w_idx = 0; claim_idx = 0; ra_idx = 0; rb_idx = 0; wdata = 0; w_lane = 0;
  endtask

  task automatic do_write(input logic [4:0] idx, input logic [31:0] d, input logic [1:0] m);
    idle_inputs();
    wen = 1; w_idx = idx; wdata = d; w_lane = m;
    cyc();
    idle_inputs();
  endtask

  int nb, nd;

  initial begin
    idle_inputs();
    rst = 1;
    model_reset();
    cyc();
    cyc();
    rst = 0;

    // Basic write / read / reset
    do_write(5'd3, 32'hDEADBEEF, 2'b11);
    ren_a = 1; ra_idx = 3;
    settle();
    check("read_idx3", rda[0], 32'hDEADBEEF);
    tick();
    rst = 1;
    settle();
    check("reset_read", rda[0], 32'h0);
    check("reset_busy", 32'(bsa[0]), 32'h0);
    tick();
    rst = 0;

    // Lane-masked forwarding
    do_write(5'd5, 32'h11112222, 2'b11);
    wen = 1; w_idx = 5; wdata = 32'hAAAABBBB; w_lane = 2'b10;
    ren_a = 1; ra_idx = 5; ren_b = 0; rb_idx = 5;
    settle();
    check("fwd_lane", rda[0], 32'hAAAA2222);
    check("ren_b_off", rdb[0], 32'h0);
    tick();
    idle_inputs();
    ren_a = 1; ra_idx = 5;
    settle();
    check("stored_lane", rda[0], 32'hAAAA2222);
    tick();

    // Scoreboard claim / release / simultaneous
    idle_inputs(); claim = 1; claim_idx = 7;
    cyc();
    idle_inputs(); wen = 1; w_idx = 7; w_release = 1; ren_a = 1; ra_idx = 7;
    settle();
    check("busy_claimed", 32'(bsa[0]), 32'h1);
    tick();
    idle_inputs(); ren_a = 1; ra_idx = 7;
    settle();
    check("busy_released", 32'(bsa[0]), 32'h0);
    tick();
    claim = 1; claim_idx = 7; wen = 1; w_idx = 7; w_release = 1;
    cyc();
    idle_inputs(); ren_a = 1; ra_idx = 7;
    settle();
    check("claim_wins", 32'(bsa[0]), 32'h1);
    tick();

    // Full sweep with a dropped mid-sweep write
    for (int i = 0; i < 16; i++) do_write(5'(i), 32'h01010101 * (i + 1), 2'b11);
    claim = 1; claim_idx = 2; cyc();
    claim_idx = 9; cyc();
    idle_inputs(); clr_req = 1;
    cyc();
    idle_inputs();
    nb = 0; nd = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        wen = 1; w_idx = 4; wdata = 32'h12345678; w_lane = 2'b11;
      end else begin
        wen = 0;
      end
      settle();
      if (cbusy[0]) nb++;
      if (cdone[0]) nd++;
      tick();
    end
    check("sweep_busy_cycles", 32'(nb), 32'd16);
    check("sweep_done_pulses", 32'(nd), 32'd1);
    idle_inputs(); ren_a = 1; ren_b = 1;
    for (int i = 0; i < 16; i++) begin
      ra_idx = 5'(i); rb_idx = 5'(i);
      settle();
      check($sformatf("cleared_reg%0d", i), rda[0], 32'h0);
      check($sformatf("cleared_busy%0d", i), 32'(bsb[0]), 32'h0);
      tick();
    end

    // Reset in the middle of a sweep
    for (int i = 1; i < 4; i++) do_write(5'(i), 32'hC0DE0000 + i, 2'b11);
    clr_req = 1; cyc(); clr_req = 0;
    for (int c = 0; c < 6; c++) cyc();
    rst = 1;
    settle();
    check("rst_mid_clr_busy", 32'(cbusy[0]), 32'h0);
    check("rst_mid_clr_done", 32'(cdone[0]), 32'h0);
    check("rst_mid_wr_ready", 32'(wrdy[0]), 32'h1);
    tick();
    rst = 0;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      ren_a = 1; ra_idx = 5'(c % 16);
      settle();
      if (cdone[0]) nd++;
      tick();
    end
    check("rst_mid_no_done", 32'(nd), 32'd0);

    // Register 0 hard-wired on the ZERO_R0 instance; out-of-range read
    idle_inputs();
    wen = 1; w_idx = 0; wdata = 32'hFFFFFFFF; w_lane = 2'b11; claim = 1; claim_idx = 0;
    ren_a = 1; ra_idx = 0;
    settle();
    check("zero_r0_fwd", rda[1], 32'h0);
    check("zero_r0_busy", 32'(bsa[1]), 32'h0);
    check("normal_r0_fwd", rda[0], 32'hFFFFFFFF);
    tick();
    idle_inputs(); ren_a = 1; ra_idx = 0;
    settle();
    check("zero_r0_busy_after", 32'(bsa[1]), 32'h0);
    check("normal_r0_busy_after", 32'(bsa[0]), 32'h1);
    tick();
    ra_idx = 16;
    settle();
    check("oob_read", rda[1], 32'h0);
    check("oob_busy", 32'(bsa[1]), 32'h0);
    tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 399) == 0);
      wen       = 1'($urandom);
      w_idx     = 5'($urandom_range(0, 17));
      wdata     = $urandom;
      w_lane    = 2'($urandom);
      w_release = 1'($urandom);
      claim     = 1'($urandom);
      claim_idx = 5'($urandom_range(0, 17));
      ren_a     = ($urandom_range(0, 7) != 0);
      ra_idx    = 5'($urandom_range(0, 17));
      ren_b     = ($urandom_range(0, 7) != 0);
      rb_idx    = ($urandom_range(0, 3) == 0) ? w_idx : 5'($urandom_range(0, 17));
      clr_req   = ($urandom_range(0, 49) == 0);
      cyc();
    end
    rst = 0;
    idle_inputs();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
